// File: rtl/cordic_range_reduce_pkg.sv
// Shared constants and types for the CORDIC argument range-reduction stage.
// ln2 constants are held in Q16.16 and rescaled to the instance's fraction width.
package cordic_range_reduce_pkg;

   localparam int unsigned RR_WIDTH = 32;
   localparam int unsigned RR_FRAC  = 16;
   localparam int unsigned RR_KW    = 8;

   localparam int unsigned LN2_FRAC   = 16;
   localparam logic [31:0] LN2_Q      = 32'h0000B172;
   localparam logic [31:0] LN2_HALF_Q = 32'h000058B9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIN  = 2'd2
   } rr_state_e;

   // Rescale a Q16.16 constant to a different fraction width
   function automatic logic [63:0] scale_q(input logic [31:0] c, input int unsigned frac);
      if (frac >= LN2_FRAC)
         return 64'(c) << (frac - LN2_FRAC);
      else
         return 64'(c) >> (LN2_FRAC - frac);
   endfunction

   // Rounding bias: ln2/2 when rounding to nearest, zero when truncating
   function automatic logic [63:0] rr_bias_q(input int unsigned frac, input bit round);
      if (round)
         return scale_q(LN2_HALF_Q, frac);
      else
         return 64'd0;
   endfunction

endpackage

// File: rtl/cordic_range_reduce_if.sv
// Handshake/data bundle between the argument source, the range reducer and the CORDIC.
interface cordic_range_reduce_if
   import cordic_range_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = RR_WIDTH,
   parameter int unsigned KW    = RR_KW
);

   logic [WIDTH-1:0] x;
   logic             en;
   logic [WIDTH-1:0] r;
   logic [KW-1:0]    k;
   logic             ovf;
   logic             valid;
   logic             busy;

   modport master (
      output x, en,
      input  r, k, ovf, valid, busy
   );

   modport slave (
      input  x, en,
      output r, k, ovf, valid, busy
   );

endinterface

// File: rtl/cordic_range_reduce.sv
// Argument range reduction x = k*ln2 + r ahead of the hyperbolic CORDIC.
// k is found by restoring division of |x| by ln2, one quotient bit per cycle.
// Optional feature macro: CORDIC_RR_ROUND_EN (round to nearest; default truncates).
module cordic_range_reduce
   import cordic_range_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = RR_WIDTH,
   parameter int unsigned FRAC  = RR_FRAC,
   parameter int unsigned KW    = RR_KW
) (
   input  logic                  clk,
   input  logic                  rst,
   cordic_range_reduce_if.slave  rr
);

`ifdef CORDIC_RR_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   localparam int unsigned ACCW = WIDTH + 1;
   localparam int unsigned KMW  = KW - 1;
   localparam int unsigned IDXW = $clog2(KW);

   localparam logic [ACCW-1:0] LN2      = ACCW'(scale_q(LN2_Q, FRAC));
   localparam logic [ACCW-1:0] RND_BIAS = ACCW'(rr_bias_q(FRAC, ROUND));
   localparam logic [ACCW-1:0] OVF_LIM  = LN2 << (KW - 1);
   localparam logic [KW-1:0]   KMAX     = {1'b0, {KMW{1'b1}}};

   rr_state_e         state_q, state_d;
   logic [ACCW-1:0]   acc_q, acc_d;
   logic              sign_q, sign_d;
   logic              ovf_q, ovf_d;
   logic [KMW-1:0]    kmag_q, kmag_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]  r_q, r_d;
   logic [KW-1:0]     k_q, k_d;
   logic              ovf_out_q, ovf_out_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic [ACCW-1:0]   x_ext;
   logic [ACCW-1:0]   x_abs;
   logic [ACCW-1:0]   acc_init;
   logic [ACCW-1:0]   step;
   logic [WIDTH-1:0]  rmag;
   logic [KW-1:0]     kext;

   // Next-state, datapath step and output formation
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sign_d    = sign_q;
      ovf_d     = ovf_q;
      kmag_d    = kmag_q;
      idx_d     = idx_q;
      r_d       = r_q;
      k_d       = k_q;
      ovf_out_d = ovf_out_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;

      // |x| needs one extra bit so the most negative input stays exact
      x_ext    = {rr.x[WIDTH-1], rr.x};
      x_abs    = rr.x[WIDTH-1] ? ACCW'(-x_ext) : x_ext;
      acc_init = x_abs + RND_BIAS;
      step     = LN2 << idx_q;
      // With rounding the remainder may dip below the bias; wraparound yields the signed value
      rmag     = WIDTH'(acc_q - RND_BIAS);
      kext     = {1'b0, kmag_q};

      case (state_q)
         ST_IDLE: begin
            if (rr.en) begin
               sign_d  = rr.x[WIDTH-1];
               acc_d   = acc_init;
               ovf_d   = (acc_init >= OVF_LIM);
               kmag_d  = '0;
               idx_d   = IDXW'(KW - 2);
               busy_d  = 1'b1;
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            if (acc_q >= step) begin
               acc_d  = acc_q - step;
               kmag_d = kmag_q | (KMW'(1) << idx_q);
            end
            if (idx_q == '0)
               state_d = ST_FIN;
            else
               idx_d = idx_q - IDXW'(1);
         end
         ST_FIN: begin
            if (ovf_q) begin
               r_d = '0;
               k_d = sign_q ? -KMAX : KMAX;
            end else begin
               r_d = sign_q ? -rmag : rmag;
               k_d = sign_q ? -kext : kext;
            end
            ovf_out_d = ovf_q;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         sign_q    <= 1'b0;
         ovf_q     <= 1'b0;
         kmag_q    <= '0;
         idx_q     <= '0;
         r_q       <= '0;
         k_q       <= '0;
         ovf_out_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         sign_q    <= sign_d;
         ovf_q     <= ovf_d;
         kmag_q    <= kmag_d;
         idx_q     <= idx_d;
         r_q       <= r_d;
         k_q       <= k_d;
         ovf_out_q <= ovf_out_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign rr.r     = r_q;
   assign rr.k     = k_q;
   assign rr.ovf   = ovf_out_q;
   assign rr.valid = valid_q;
   assign rr.busy  = busy_q;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Self-checking bench for cordic_range_reduce: directed spec vectors, randomized
// arguments against a division-based reference model, busy/abort/back-to-back behaviour.
module tb_cordic_range_reduce;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned KW    = 8;
   localparam longint      LN2   = 45426;
   localparam longint      HALF  = 22713;

`ifdef CORDIC_RR_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cordic_range_reduce_if #(.WIDTH(WIDTH), .KW(KW)) bus ();

   cordic_range_reduce #(.WIDTH(WIDTH), .FRAC(16), .KW(KW)) dut (
      .clk (clk),
      .rst (rst),
      .rr  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference: x = k*ln2 + r with k from integer division of |x| by ln2
   function automatic void model(input logic [31:0] xin, output logic [31:0] re,
                                 output logic [7:0] ke, output logic oe);
      longint ax, kk, rm;
      bit     s;
      s  = xin[31];
      ax = longint'($signed(xin));
      if (ax < 0) ax = -ax;
      kk = ROUND ? (ax + HALF) / LN2 : ax / LN2;
      if (kk > 127) begin
         oe = 1'b1;
         ke = s ? 8'h81 : 8'h7F;
         re = 32'h0;
      end else begin
         oe = 1'b0;
         rm = ax - kk * LN2;
         re = 32'(s ? -rm : rm);
         ke = 8'(s ? -kk : kk);
      end
   endfunction

   // Start one operation from a negedge and wait (bounded) for valid; ends on the valid negedge
   task automatic run_op(input logic [31:0] xin, output logic [31:0] ro, output logic [7:0] ko,
                         output logic oo, output int lat, output logic busy_acc);
      bus.x  = xin;
      bus.en = 1'b1;
      @(negedge clk);
      bus.en   = 1'b0;
      busy_acc = bus.busy;
      lat      = 1;
      while (!bus.valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      ro = bus.r;
      ko = bus.k;
      oo = bus.ovf;
   endtask

   task automatic test_reset();
      rst    = 1'b0;
      bus.en = 1'b0;
      bus.x  = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.r, bus.k, bus.ovf, bus.valid, bus.busy} !== 43'h0) begin
         errors++;
         $display("FAIL reset: r=%h k=%h ovf=%b valid=%b busy=%b, required all zero",
                  bus.r, bus.k, bus.ovf, bus.valid, bus.busy);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] xs [6];
      logic [31:0] ro, re;
      logic [7:0]  ko, ke;
      logic        oo, oe, ba;
      int          lat;
      xs[0] = 32'h00020000; xs[1] = 32'hFFFE0000; xs[2] = 32'h00000000;
      xs[3] = 32'h00600000; xs[4] = 32'h80000000; xs[5] = 32'h7FFFFFFF;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin re = ROUND ? 32'hFFFFEBAA : 32'h00009D1C; ke = ROUND ? 8'd3 : 8'd2; oe = 1'b0; end
            1: begin re = ROUND ? 32'h00001456 : 32'hFFFF62E4; ke = ROUND ? 8'hFD : 8'hFE; oe = 1'b0; end
            2: begin re = 32'h0; ke = 8'h00; oe = 1'b0; end
            3: begin re = 32'h0; ke = 8'h7F; oe = 1'b1; end
            4: begin re = 32'h0; ke = 8'h81; oe = 1'b1; end
            default: begin re = 32'h0; ke = 8'h7F; oe = 1'b1; end
         endcase
         run_op(xs[i], ro, ko, oo, lat, ba);
         checks++;
         if (ro !== re || ko !== ke || oo !== oe) begin
            errors++;
            $display("FAIL directed x=%h: r=%h k=%h ovf=%b, required r=%h k=%h ovf=%b",
                     xs[i], ro, ko, oo, re, ke, oe);
         end
         checks++;
         if (lat != KW + 1 || ba !== 1'b1) begin
            errors++;
            $display("FAIL latency x=%h: edges=%0d busy=%b, required edges=%0d busy=1",
                     xs[i], lat, ba, KW + 1);
         end
         @(negedge clk);
         checks++;
         if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse x=%h: valid=%b busy=%b one cycle later, required 0 0",
                     xs[i], bus.valid, bus.busy);
         end
      end
   endtask

   task automatic test_boundary();
      logic [31:0] xs [6];
      logic [31:0] ro, re;
      logic [7:0]  ko, ke;
      logic        oo, oe, ba;
      int          lat;
      xs[0] = 32'(LN2 * 128 - 1 - (ROUND ? HALF : 0));
      xs[1] = 32'(LN2 * 128 - (ROUND ? HALF : 0));
      xs[2] = -xs[0];
      xs[3] = -xs[1];
      xs[4] = 32'(HALF);
      xs[5] = 32'(-LN2);
      for (int i = 0; i < 6; i++) begin
         model(xs[i], re, ke, oe);
         run_op(xs[i], ro, ko, oo, lat, ba);
         checks++;
         if (ro !== re || ko !== ke || oo !== oe || lat != KW + 1) begin
            errors++;
            $display("FAIL boundary x=%h: r=%h k=%h ovf=%b lat=%0d, required r=%h k=%h ovf=%b lat=%0d",
                     xs[i], ro, ko, oo, lat, re, ke, oe, KW + 1);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] xin, ro, re;
      logic [7:0]  ko, ke;
      logic        oo, oe, ba;
      int          lat, m;
      longint      rs;
      bit          bound_ok;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            xin = $urandom;
         end else begin
            m   = int'($urandom_range(0, 6000000));
            xin = $urandom_range(0, 1) ? 32'(-m) : 32'(m);
         end
         model(xin, re, ke, oe);
         run_op(xin, ro, ko, oo, lat, ba);
         checks++;
         if (ro !== re || ko !== ke || oo !== oe || lat != KW + 1) begin
            errors++;
            $display("FAIL random x=%h: r=%h k=%h ovf=%b lat=%0d, required r=%h k=%h ovf=%b lat=%0d",
                     xin, ro, ko, oo, lat, re, ke, oe, KW + 1);
         end
         if (!oe) begin
            rs = longint'($signed(ro));
            if (ROUND)
               bound_ok = (rs <= HALF) && (rs >= -HALF);
            else
               bound_ok = (rs < LN2) && (rs > -LN2) && (rs == 0 || (rs < 0) == xin[31]);
            checks++;
            if (!bound_ok) begin
               errors++;
               $display("FAIL r_bound x=%h: r=%h outside the reduced range", xin, ro);
            end
         end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   task automatic test_ignore_en();
      logic [31:0] ro, re;
      logic [7:0]  ko, ke;
      logic        oo, oe;
      int          nvalid, first;
      model(32'h00020000, re, ke, oe);
      bus.x  = 32'h00020000;
      bus.en = 1'b1;
      nvalid = 0;
      first  = 0;
      ro = '0; ko = '0; oo = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         @(negedge clk);
         bus.en = 1'b0;
         if (e == 3 || e == 8) begin
            bus.x  = 32'hFFE00000;
            bus.en = 1'b1;
         end
         if (bus.valid) begin
            nvalid++;
            if (nvalid == 1) begin
               first = e;
               ro = bus.r; ko = bus.k; oo = bus.ovf;
            end
         end
      end
      checks++;
      if (nvalid != 1 || first != KW + 1) begin
         errors++;
         $display("FAIL ignore_en: %0d valid pulses first at edge %0d, required 1 at edge %0d",
                  nvalid, first, KW + 1);
      end
      checks++;
      if (ro !== re || ko !== ke || oo !== oe) begin
         errors++;
         $display("FAIL ignore_en_result: r=%h k=%h ovf=%b, required r=%h k=%h ovf=%b",
                  ro, ko, oo, re, ke, oe);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xs [4];
      logic [31:0] ro, re;
      logic [7:0]  ko, ke;
      logic        oo, oe, ba;
      int          lat;
      xs[0] = 32'h00020000; xs[1] = 32'hFFFE0000; xs[2] = 32'h0003A5C2; xs[3] = 32'hFFF80001;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) @(negedge clk);
         model(xs[i], re, ke, oe);
         run_op(xs[i], ro, ko, oo, lat, ba);
         checks++;
         if (ba !== 1'b1 || ro !== re || ko !== ke || oo !== oe || lat != KW + 1) begin
            errors++;
            $display("FAIL back_to_back x=%h: busy=%b r=%h k=%h ovf=%b lat=%0d, required busy=1 r=%h k=%h ovf=%b lat=%0d",
                     xs[i], ba, ro, ko, oo, lat, re, ke, oe, KW + 1);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      logic [31:0] ro, re;
      logic [7:0]  ko, ke;
      logic        oo, oe, ba;
      int          lat, nvalid;
      bus.x  = 32'h00050000;
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.r, bus.k, bus.ovf, bus.valid, bus.busy} !== 43'h0) begin
         errors++;
         $display("FAIL abort_reset: r=%h k=%h ovf=%b valid=%b busy=%b, required all zero",
                  bus.r, bus.k, bus.ovf, bus.valid, bus.busy);
      end
      rst    = 1'b1;
      nvalid = 0;
      for (int e = 0; e < 15; e++) begin
         @(negedge clk);
         if (bus.valid) nvalid++;
      end
      checks++;
      if (nvalid != 0) begin
         errors++;
         $display("FAIL abort_no_valid: %0d valid pulses after abort, required 0", nvalid);
      end
      model(32'h00020000, re, ke, oe);
      run_op(32'h00020000, ro, ko, oo, lat, ba);
      checks++;
      if (ro !== re || ko !== ke || oo !== oe || lat != KW + 1) begin
         errors++;
         $display("FAIL abort_recover: r=%h k=%h ovf=%b lat=%0d, required r=%h k=%h ovf=%b lat=%0d",
                  ro, ko, oo, lat, re, ke, oe, KW + 1);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_boundary();
      test_random();
      test_ignore_en();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
